// File: rtl/gen2_cmd_pkg.sv
// Gen2 reader-command constants: command codes, prefixes, lengths, error codes and CRC-5 definition.
package gen2_cmd_pkg;

  localparam int unsigned TYPE_W = 3;
  localparam int unsigned LEN_W  = 5;
  localparam int unsigned ERR_W  = 2;
  localparam int unsigned CRC_W  = 5;

  typedef enum logic [TYPE_W-1:0] {
    CMD_NONE     = 3'd0,
    CMD_QUERYREP = 3'd1,
    CMD_ACK      = 3'd2,
    CMD_QUERY    = 3'd3,
    CMD_QUERYADJ = 3'd4
  } cmd_type_e;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE   = 2'd0,
    ERR_PREFIX = 2'd1,
    ERR_TRUNC  = 2'd2,
    ERR_CRC    = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFIX,
    ST_COLLECT,
    ST_DRAIN
  } state_e;

  localparam logic [1:0] PFX_QUERYREP = 2'b00;
  localparam logic [1:0] PFX_ACK      = 2'b01;
  localparam logic [1:0] PFX_LONG     = 2'b10;
  localparam logic [3:0] PFX_QUERY    = 4'b1000;
  localparam logic [3:0] PFX_QUERYADJ = 4'b1001;

  localparam logic [LEN_W-1:0] LEN_QUERYREP = 5'd4;
  localparam logic [LEN_W-1:0] LEN_ACK      = 5'd18;
  localparam logic [LEN_W-1:0] LEN_QUERY    = 5'd22;
  localparam logic [LEN_W-1:0] LEN_QUERYADJ = 5'd9;

  // x^5 + x^3 + 1
  localparam logic [CRC_W-1:0] CRC5_POLY   = 5'b01001;
  localparam logic [CRC_W-1:0] CRC5_PRESET = 5'b01001;

  // One MSB-first serial step of the CRC-5 register.
  function automatic logic [CRC_W-1:0] crc5_step(input logic [CRC_W-1:0] crc, input logic din);
    crc5_step = {crc[CRC_W-2:0], 1'b0} ^ (((crc[CRC_W-1] ^ din) == 1'b1) ? CRC5_POLY : '0);
  endfunction

endpackage

// File: rtl/crc5_gen2.sv
// Serial CRC-5 register: init loads the preset, en shifts in one data bit MSB first.
module crc5_gen2
  import gen2_cmd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             en,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= '0;
    end else if (init) begin
      crc <= CRC5_PRESET;
    end else if (en) begin
      crc <= crc5_step(crc, din);
    end
  end

endmodule

// File: rtl/pie_cmd_deframer.sv
// Deframes decoded PIE bits into Gen2 reader commands: prefix decode, length collect,
// CRC-5 check for Query, and truncation / bad-prefix error reporting.
module pie_cmd_deframer
  import gen2_cmd_pkg::*;
#(
  parameter int unsigned MAX_BITS = 22
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic                bit_in,
  input  logic                bit_valid,
  input  logic                frame_sync,
  output logic                cmd_valid,
  output logic [TYPE_W-1:0]   cmd_type,
  output logic [LEN_W-1:0]    cmd_len,
  output logic [MAX_BITS-1:0] cmd_payload,
  output logic                cmd_err,
  output logic [ERR_W-1:0]    err_code
);

  localparam int unsigned CNT_W = $clog2(MAX_BITS + 1);

  state_e              r_state, w_state_nxt;
  logic                r_fs;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [MAX_BITS-1:0] r_sr, w_sr_nxt;
  cmd_type_e           r_ftype, w_ftype;
  logic [LEN_W-1:0]    r_flen, w_flen;
  logic [CRC_W-1:0]    w_crc, w_crc_nxt;
  logic                w_rise, w_fall, w_acc, w_start, w_check, w_valid, w_err;
  err_code_e           w_ecode;

  assign w_rise    = frame_sync & ~r_fs;
  assign w_fall    = ~frame_sync & r_fs;
  assign w_acc     = bit_valid & frame_sync & ((r_state == ST_PREFIX) || (r_state == ST_COLLECT));
  assign w_start   = (r_state == ST_IDLE) & w_rise;
  assign w_cnt_nxt = (r_cnt == CNT_W'(MAX_BITS)) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_sr_nxt  = {r_sr[MAX_BITS-2:0], bit_in};
  assign w_crc_nxt = crc5_step(w_crc, bit_in);

  crc5_gen2 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (w_start),
    .en   (w_acc),
    .din  (bit_in),
    .crc  (w_crc)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Decisions look at the bit being accepted this cycle so pulses land one cycle after it.
  always_comb begin
    w_state_nxt = r_state;
    w_ftype     = r_ftype;
    w_flen      = r_flen;
    w_check     = 1'b0;
    w_valid     = 1'b0;
    w_err       = 1'b0;
    w_ecode     = ERR_NONE;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_PREFIX;
          w_ftype     = CMD_NONE;
          w_flen      = '0;
        end
      end
      ST_PREFIX: begin
        if (w_fall) begin
          w_err       = 1'b1;
          w_ecode     = ERR_TRUNC;
          w_state_nxt = ST_IDLE;
        end else if (w_acc) begin
          if (w_cnt_nxt == CNT_W'(2)) begin
            case (w_sr_nxt[1:0])
              PFX_QUERYREP: begin w_ftype = CMD_QUERYREP; w_flen = LEN_QUERYREP; end
              PFX_ACK:      begin w_ftype = CMD_ACK;      w_flen = LEN_ACK;      end
              PFX_LONG:     w_ftype = CMD_NONE;
              default:      begin w_err = 1'b1; w_ecode = ERR_PREFIX; end
            endcase
          end else if (w_cnt_nxt == CNT_W'(4)) begin
            case (w_sr_nxt[3:0])
              PFX_QUERY:    begin w_ftype = CMD_QUERY;    w_flen = LEN_QUERY;    end
              PFX_QUERYADJ: begin w_ftype = CMD_QUERYADJ; w_flen = LEN_QUERYADJ; end
              default:      begin w_err = 1'b1; w_ecode = ERR_PREFIX; end
            endcase
          end
          if (w_err) begin
            w_state_nxt = ST_DRAIN;
          end else if (w_ftype != CMD_NONE) begin
            w_state_nxt = ST_COLLECT;
            w_check     = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (w_fall) begin
          w_err       = 1'b1;
          w_ecode     = ERR_TRUNC;
          w_state_nxt = ST_IDLE;
        end else if (w_acc) begin
          w_check = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (w_fall) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_check && (32'(w_cnt_nxt) == 32'(w_flen))) begin
      w_state_nxt = ST_DRAIN;
      if ((w_ftype == CMD_QUERY) && (w_crc_nxt != '0)) begin
        w_err   = 1'b1;
        w_ecode = ERR_CRC;
      end else begin
        w_valid = 1'b1;
      end
    end
  end

  // Start of frame is seen as "already high" after reset so a held frame_sync cannot open one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fs        <= 1'b1;
      r_cnt       <= '0;
      r_sr        <= '0;
      r_ftype     <= CMD_NONE;
      r_flen      <= '0;
      cmd_valid   <= 1'b0;
      cmd_err     <= 1'b0;
      cmd_type    <= '0;
      cmd_len     <= '0;
      cmd_payload <= '0;
      err_code    <= '0;
    end else begin
      r_fs      <= frame_sync;
      r_ftype   <= w_ftype;
      r_flen    <= w_flen;
      cmd_valid <= w_valid;
      cmd_err   <= w_err;
      if (w_start) begin
        r_cnt <= '0;
        r_sr  <= '0;
      end else if (w_acc) begin
        r_cnt <= w_cnt_nxt;
        r_sr  <= w_sr_nxt;
      end
      if (w_valid) begin
        cmd_type    <= w_ftype;
        cmd_len     <= w_flen;
        cmd_payload <= w_sr_nxt;
        err_code    <= ERR_NONE;
      end
      if (w_err) err_code <= w_ecode;
    end
  end

endmodule

// File: tb/tb_pie_cmd_deframer.sv
// Randomized frame bench for pie_cmd_deframer against a bit-list command model.
module tb_pie_cmd_deframer;

  localparam int MAXB = 22;

  logic            clk = 1'b0;
  logic            rst, bit_in, bit_valid, frame_sync;
  logic            cmd_valid, cmd_err;
  logic [2:0]      cmd_type;
  logic [4:0]      cmd_len;
  logic [MAXB-1:0] cmd_payload;
  logic [1:0]      err_code;

  pie_cmd_deframer #(.MAX_BITS(MAXB)) dut (
    .clk         (clk),
    .rst         (rst),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .frame_sync  (frame_sync),
    .cmd_valid   (cmd_valid),
    .cmd_type    (cmd_type),
    .cmd_len     (cmd_len),
    .cmd_payload (cmd_payload),
    .cmd_err     (cmd_err),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0, cyc = 0;
  int v_cnt, e_cnt, v_cyc, e_cyc;
  logic [2:0]      v_type;
  logic [4:0]      v_len;
  logic [MAXB-1:0] v_pay;
  logic [1:0]      v_ecode, e_code;
  bit              fb[$];
  int              bc[$];
  int              fall_cyc;
  int              exp_kind, exp_code, exp_idx, exp_type, exp_len;
  logic [MAXB-1:0] exp_pay;
  logic [2:0]      last_type;
  logic [4:0]      last_len;
  logic [MAXB-1:0] last_pay;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Advance one clock; sample just after the edge and log any pulses.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check("valid_err_exclusive", {31'd0, cmd_valid & cmd_err}, 32'd0);
    if (cmd_valid) begin
      v_cnt++; v_cyc = cyc; v_type = cmd_type; v_len = cmd_len; v_pay = cmd_payload; v_ecode = err_code;
    end
    if (cmd_err) begin
      e_cnt++; e_cyc = cyc; e_code = err_code;
    end
  endtask

  function automatic logic [4:0] crc_over(input int n);
    logic [4:0] c;
    logic       t;
    c = 5'b01001;
    for (int i = 0; i < n; i++) begin
      t = c[4] ^ fb[i];
      c = {c[3:0], 1'b0} ^ (t ? 5'b01001 : 5'b00000);
    end
    return c;
  endfunction

  task automatic push_word(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) fb.push_back(w[i]);
  endtask

  // kind: 0 QueryRep, 1 ACK, 2 Query, 3 QueryAdjust, 4 bad prefix
  task automatic build(input int kind);
    logic [4:0] c;
    fb.delete();
    case (kind)
      0: begin push_word(32'b00, 2); push_word($urandom, 2); end
      1: begin push_word(32'b01, 2); push_word($urandom, 16); end
      2: begin
        push_word(32'b1000, 4); push_word($urandom, 13);
        c = crc_over(17);
        push_word({27'd0, c}, 5);
      end
      3: begin push_word(32'b1001, 4); push_word($urandom, 5); end
      default: begin
        if ($urandom_range(0, 1) == 0) push_word(32'b11, 2);
        else begin push_word(32'b101, 3); push_word($urandom, 1); end
      end
    endcase
    push_word($urandom, $urandom_range(0, 3));
  endtask

  // Expected outcome of a frame whose first n bits of fb were delivered before frame_sync fell.
  task automatic model(input int n);
    int t, l;
    exp_kind = 2; exp_code = 2; exp_idx = -1; exp_type = 0; exp_len = 0; exp_pay = '0;
    if (n < 2) return;
    if (fb[0] == 1'b0) begin
      t = fb[1] ? 2 : 1;
      l = fb[1] ? 18 : 4;
    end else if (fb[1] == 1'b1) begin
      exp_code = 1; exp_idx = 1; return;
    end else begin
      if (n < 4) return;
      if (fb[2] == 1'b0 && fb[3] == 1'b0)      begin t = 3; l = 22; end
      else if (fb[2] == 1'b0 && fb[3] == 1'b1) begin t = 4; l = 9;  end
      else begin exp_code = 1; exp_idx = 3; return; end
    end
    if (n < l) return;
    exp_idx = l - 1;
    if (t == 3 && crc_over(22) != 5'd0) begin exp_code = 3; return; end
    exp_kind = 1; exp_type = t; exp_len = l;
    for (int i = 0; i < l; i++) exp_pay = {exp_pay[MAXB-2:0], fb[i]};
  endtask

  task automatic run_frame(input string tag, input int n_send, input bit glitch);
    int ecyc;
    model(n_send);
    v_cnt = 0; e_cnt = 0; bc.delete();
    frame_sync = 1'b0; bit_valid = 1'($urandom_range(0, 1)); bit_in = 1'($urandom);
    step();
    bit_valid = 1'b0;
    frame_sync = 1'b1;
    step();
    for (int i = 0; i < n_send; i++) begin
      bit_in = fb[i]; bit_valid = 1'b1;
      step();
      bc.push_back(cyc);
      bit_valid = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
    frame_sync = 1'b0; bit_valid = glitch; bit_in = 1'($urandom);
    step();
    fall_cyc = cyc;
    bit_valid = 1'b0;
    step();
    step();
    ecyc = (exp_idx >= 0) ? bc[exp_idx] : fall_cyc;
    check({tag, "_n_valid"}, v_cnt, (exp_kind == 1) ? 1 : 0);
    check({tag, "_n_err"}, e_cnt, (exp_kind == 2) ? 1 : 0);
    if (exp_kind == 1 && v_cnt == 1) begin
      check({tag, "_valid_cycle"}, v_cyc, ecyc);
      check({tag, "_type"}, {29'd0, v_type}, exp_type);
      check({tag, "_len"}, {27'd0, v_len}, exp_len);
      check({tag, "_payload"}, {10'd0, v_pay}, {10'd0, exp_pay});
      check({tag, "_errcode_cleared"}, {30'd0, v_ecode}, 32'd0);
      last_type = 3'(exp_type); last_len = 5'(exp_len); last_pay = exp_pay;
    end
    if (exp_kind == 2 && e_cnt == 1) begin
      check({tag, "_err_cycle"}, e_cyc, ecyc);
      check({tag, "_err_code"}, {30'd0, e_code}, exp_code);
      check({tag, "_errcode_held"}, {30'd0, err_code}, exp_code);
      check({tag, "_type_held"}, {29'd0, cmd_type}, {29'd0, last_type});
      check({tag, "_payload_held"}, {10'd0, cmd_payload}, {10'd0, last_pay});
    end
  endtask

  initial begin
    int kind, n, r;
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; frame_sync = 1'b0;
    v_cnt = 0; e_cnt = 0;
    last_type = '0; last_len = '0; last_pay = '0;
    repeat (3) step();
    check("rst_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_err", {31'd0, cmd_err}, 32'd0);
    check("rst_type", {29'd0, cmd_type}, 32'd0);
    check("rst_payload", {10'd0, cmd_payload}, 32'd0);
    rst = 1'b0;
    step();

    fb.delete(); push_word(32'b0010, 4);
    run_frame("qrep", 4, 1'b0);
    check("qrep_payload_abs", {10'd0, cmd_payload}, 32'h2);

    fb.delete(); push_word(32'b01, 2); push_word(32'hA5C3, 16);
    run_frame("ack", 18, 1'b1);
    check("ack_payload_abs", {10'd0, cmd_payload}, 32'h1A5C3);

    build(2);
    run_frame("query_ok", 22, 1'b0);
    fb[10] = ~fb[10];
    run_frame("query_bad", 22, 1'b0);

    fb.delete(); push_word(32'b11, 2); push_word($urandom, 5);
    run_frame("bad_pfx", 7, 1'b0);
    build(0);
    run_frame("after_bad", fb.size(), 1'b0);

    build(3);
    run_frame("adj_trunc", 6, 1'b1);

    // Reset mid-ACK: frame abandoned silently and stays dead until a fresh rise.
    build(1);
    frame_sync = 1'b0; step();
    frame_sync = 1'b1; step();
    for (int i = 0; i < 8; i++) begin bit_in = fb[i]; bit_valid = 1'b1; step(); end
    bit_valid = 1'b0;
    rst = 1'b1; step();
    rst = 1'b0;
    check("mid_rst_type", {29'd0, cmd_type}, 32'd0);
    check("mid_rst_len", {27'd0, cmd_len}, 32'd0);
    check("mid_rst_errcode", {30'd0, err_code}, 32'd0);
    v_cnt = 0; e_cnt = 0;
    for (int i = 8; i < 18; i++) begin bit_in = fb[i]; bit_valid = 1'b1; step(); end
    bit_valid = 1'b0;
    frame_sync = 1'b0; step(); step();
    check("mid_rst_no_valid", v_cnt, 32'd0);
    check("mid_rst_no_err", e_cnt, 32'd0);
    last_type = '0; last_len = '0; last_pay = '0;

    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(0, 4);
      build(kind);
      n = fb.size();
      r = $urandom_range(0, 9);
      if (r < 2) n = $urandom_range(0, fb.size() - 1);
      else if (r == 2 && kind == 2) fb[$urandom_range(0, 21)] ^= 1'b1;
      run_frame("rand", n, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
